// File: rtl/param_register_file.sv
// ----------------------------------------------------------------------------
// param_register_file
//
// Purpose:
//   DEPTH x WIDTH register file for the CPU datapath with two combinational
//   read ports and one synchronous write port. Entry 0 can be hardwired to
//   zero (ZERO_REG=1). An asynchronous active-low reset clears every entry.
//
// Parameters:
//   WIDTH     data width of each entry
//   DEPTH     number of entries, 2..2**ADDR_W (not necessarily a power of two)
//   ADDR_W    address width
//   ZERO_REG  1: entry 0 reads as 0 and ignores writes; 0: ordinary storage
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low; clears all entries
//   wrenable    write enable, sampled at posedge clk
//   write_addr  write address; writes at or above DEPTH are dropped
//   write_data  write data
//   read_addr1  read port 1 address
//   read_data1  read port 1 data (combinational; 0 when out of range)
//   read_addr2  read port 2 address
//   read_data2  read port 2 data (combinational; 0 when out of range)
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, an accepted write in the current cycle is
//                      forwarded to any read port addressing the same entry
//                      (0-cycle write-to-read). Undefined: reads reflect
//                      stored state only (1-cycle write-to-read).
// ----------------------------------------------------------------------------
module param_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrenable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    output logic [WIDTH-1:0]  read_data1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [WIDTH-1:0]  read_data2
);

    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             write_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Out-of-range and hardwired-zero addresses never read stored data.
    function automatic logic [WIDTH-1:0] stored(input logic [ADDR_W-1:0] a);
        if (!in_range(a) || is_zero_entry(a)) begin
            return '0;
        end
        return mem[a];
    endfunction

    // A write is accepted only outside reset and to a real, writable entry.
    // The same qualifier gates the bypass so a dropped write is never forwarded.
    assign write_ok = rst_n && wrenable && in_range(write_addr) && !is_zero_entry(write_addr);

    // NOTE: the storage array is reset here on purpose -- every entry must read
    // 0 while rst_n is low, so the array cannot be left as reset-less RAM; all
    // state updates use <= so the read ports see old data until after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[write_addr] <= write_data;
        end
    end

    // NOTE: each output gets its full value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    always_comb begin
        read_data1 = stored(read_addr1);
`ifdef REGFILE_BYPASS_EN
        if (write_ok && (read_addr1 == write_addr)) begin
            read_data1 = write_data;
        end
`endif
    end

    always_comb begin
        read_data2 = stored(read_addr2);
`ifdef REGFILE_BYPASS_EN
        if (write_ok && (read_addr2 == write_addr)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_param_register_file.sv
// ----------------------------------------------------------------------------
// tb_param_register_file
//
// Two instances share clock, reset and stimulus:
//   dut_a : DEPTH=24, ZERO_REG=1 (range check and hardwired zero)
//   dut_b : DEPTH=32, ZERO_REG=0 (entry 0 is ordinary storage)
// The driver applies inputs 1 time unit after posedge, asks a reference model
// what each read port must show, and queues those expectations. A separate
// monitor pops and compares them a little later, away from any clock edge.
// ----------------------------------------------------------------------------
module tb_param_register_file;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NADDR  = 1 << ADDR_W;

    typedef struct {
        int          dut;
        int          port;
        int          addr;
        logic [31:0] exp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wrenable;
    logic [ADDR_W-1:0] write_addr;
    logic [WIDTH-1:0]  write_data;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [WIDTH-1:0]  rd1_a, rd2_a, rd1_b, rd2_b;

    // Reference model: plain arrays of stored words plus per-instance config.
    logic [31:0] model [2][NADDR];
    int          cfg_depth [2] = '{24, 32};
    bit          cfg_zero  [2] = '{1'b1, 1'b0};

    exp_t exp_q [$];
    event sample_ev;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    param_register_file #(.WIDTH(WIDTH), .DEPTH(24), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrenable   (wrenable),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_data1 (rd1_a),
        .read_addr2 (read_addr2),
        .read_data2 (rd2_a)
    );

    param_register_file #(.WIDTH(WIDTH), .DEPTH(32), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrenable   (wrenable),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_data1 (rd1_b),
        .read_addr2 (read_addr2),
        .read_data2 (rd2_b)
    );

    // ---------------- reference model ----------------
    function automatic bit writable(int d, int a);
        return (a < cfg_depth[d]) && !(cfg_zero[d] && a == 0);
    endfunction

    function automatic logic [31:0] ref_read(int d, int a);
`ifdef REGFILE_BYPASS_EN
        if (rst_n === 1'b1 && wrenable === 1'b1 && a == int'(write_addr) && writable(d, a)) begin
            return write_data;
        end
`endif
        if (a >= cfg_depth[d] || (cfg_zero[d] && a == 0)) begin
            return 32'h0;
        end
        return model[d][a];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < NADDR; a++) begin
                model[d][a] = 32'h0;
            end
        end
    endtask

    // The inputs are stable at the edge (they change 1 unit later), so the
    // model commits exactly the write the DUT sees.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && wrenable === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (writable(d, int'(write_addr))) begin
                    model[d][int'(write_addr)] = write_data;
                end
            end
        end
    end

    // ---------------- scoreboard producer ----------------
    task automatic push_reads();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            for (int p = 1; p <= 2; p++) begin
                e.dut  = d;
                e.port = p;
                e.addr = (p == 1) ? int'(read_addr1) : int'(read_addr2);
                e.exp  = ref_read(d, e.addr);
                exp_q.push_back(e);
            end
        end
        ->sample_ev;
    endtask

    // One clock cycle of stimulus, applied 1 unit after posedge.
    task automatic drive(input bit we, input int wa, input logic [31:0] wd, input int r1, input int r2);
        @(posedge clk);
        #1;
        wrenable   = we;
        write_addr = ADDR_W'(wa);
        write_data = wd;
        read_addr1 = ADDR_W'(r1);
        read_addr2 = ADDR_W'(r2);
        push_reads();
    endtask

    // Change rst_n mid-cycle (called right after drive, so no edge intervenes).
    task automatic set_rst_mid(input logic v);
        #5;
        rst_n = v;
        if (!v) begin
            clear_model();
        end
        push_reads();
    endtask

    task automatic sweep_all();
        for (int i = 0; i < NADDR; i += 2) begin
            drive(1'b0, 0, 32'h0, i, i + 1);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case ({e.dut[0], e.port == 2})
                    2'b00:   act = rd1_a;
                    2'b01:   act = rd2_a;
                    2'b10:   act = rd1_b;
                    default: act = rd2_b;
                endcase
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL dut%s.rd%0d addr=%0d: got %h, expected %h at %0t",
                             (e.dut == 0) ? "_a" : "_b", e.port, e.addr, act, e.exp, $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit we;
        int wa, r1, r2;

        wrenable   = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_addr1 = '0;
        read_addr2 = 5'd3;
        rst_n      = 1'b1;
        clear_model();
        #2;
        rst_n = 1'b0;
        clear_model();
        push_reads();
        #5;
        rst_n = 1'b1;
        push_reads();

        // Reset clears everything without a clock edge.
        for (int i = 1; i < NADDR; i++) begin
            drive(1'b1, i, 32'hDEAD_BEEF, i, 30);
        end
        sweep_all();
        drive(1'b0, 0, 32'h0, 5, 17);
        set_rst_mid(1'b0);
        sweep_all();
        drive(1'b0, 0, 32'h0, 1, 31);
        set_rst_mid(1'b1);

        // Basic write/read, ports on different entries.
        drive(1'b1, 5, 32'h1234_5678, 5, 6);
        drive(1'b1, 6, 32'hCAFE_F00D, 5, 6);
        drive(1'b0, 0, 32'h0, 5, 6);

        // Entry 0: hardwired zero in dut_a, ordinary in dut_b.
        drive(1'b1, 0, 32'hFFFF_FFFF, 0, 0);
        drive(1'b0, 0, 32'h0, 0, 0);

        // Out-of-range write on dut_a (DEPTH=24).
        drive(1'b1, 30, 32'hA5A5_A5A5, 30, 23);
        sweep_all();

        // Same-cycle read of the write target.
        drive(1'b1, 7, 32'h1, 7, 7);
        drive(1'b1, 7, 32'h2, 7, 7);
        drive(1'b0, 0, 32'h0, 7, 7);

        // Reset falls before the edge of a pending write; reset wins,
        // and the held write lands on the first edge after release.
        drive(1'b1, 9, 32'h55, 9, 9);
        set_rst_mid(1'b0);
        drive(1'b1, 9, 32'h55, 9, 9);
        set_rst_mid(1'b1);
        drive(1'b0, 0, 32'h0, 9, 9);

        // Randomized traffic, biased toward reading the write target.
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 3) != 0);
            wa = $urandom_range(0, NADDR - 1);
            r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NADDR - 1);
            r2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NADDR - 1);
            drive(we, wa, $urandom, r1, r2);
            if (i == 200) begin
                set_rst_mid(1'b0);
                drive(1'b1, wa, $urandom, r1, r2);
                set_rst_mid(1'b1);
            end
        end
        sweep_all();

        @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
